// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide main-memory port between the I-cache
// miss path and the D-cache miss/write-back path.
// Transactions are serialised with round-robin priority. All memory-side
// strobes and all requester-side completions come straight from registers.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_stateNext;

    // 0 = I-cache wins a tie, 1 = D-cache wins a tie
    logic r_prioD;

    logic              r_memRead;
    logic              r_memWrite;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_iRdata;
    logic [DATA_W-1:0] r_dRdata;
    logic              r_iReady;
    logic              r_dReady;

    logic w_dReq;
    logic w_grantI;
    logic w_grantD;
    logic w_complete;

    // A D request is either direction; an illegal read+write is treated as a write
    assign w_dReq = d_read | d_write;

    // State register; reset abandons any in-flight transaction
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state logic plus grant/complete decodes for the datapath
    always_comb begin
        w_stateNext = r_state;
        w_grantI    = 1'b0;
        w_grantD    = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_read && (!w_dReq || !r_prioD)) begin
                    w_grantI    = 1'b1;
                    w_stateNext = BUSY_I;
                end else if (w_dReq) begin
                    w_grantD    = 1'b1;
                    w_stateNext = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ready) begin
                    w_complete  = 1'b1;
                    w_stateNext = DONE;
                end
            end
            DONE: begin
                // one dead cycle lets the owner drop its request after ready
                w_stateNext = IDLE;
            end
            default: begin
                w_stateNext = IDLE;
            end
        endcase
    end

    // Memory-side strobes, latched address/data and round-robin priority
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_prioD    <= 1'b0;
        end else if (w_grantI) begin
            r_memRead  <= 1'b1;
            r_memWrite <= 1'b0;
            r_memAddr  <= i_addr;
        end else if (w_grantD) begin
            r_memRead  <= ~d_write;
            r_memWrite <= d_write;
            r_memAddr  <= d_addr;
            r_memWdata <= d_wdata;
        end else if (w_complete) begin
            r_memRead  <= 1'b0;
            r_memWrite <= 1'b0;
            r_prioD    <= (r_state == BUSY_I);
        end
    end

    // Requester-side completion pulses and returned read blocks
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iRdata <= '0;
            r_dRdata <= '0;
            r_iReady <= 1'b0;
            r_dReady <= 1'b0;
        end else begin
            r_iReady <= 1'b0;
            r_dReady <= 1'b0;
            if (w_complete) begin
                if (r_state == BUSY_I) begin
                    r_iReady <= 1'b1;
                    r_iRdata <= mem_rdata;
                end else begin
                    r_dReady <= 1'b1;
                    if (r_memRead) begin
                        r_dRdata <= mem_rdata;
                    end
                end
            end
        end
    end

    assign mem_read  = r_memRead;
    assign mem_write = r_memWrite;
    assign mem_addr  = r_memAddr;
    assign mem_wdata = r_memWdata;
    assign i_rdata   = r_iRdata;
    assign d_rdata   = r_dRdata;
    assign i_ready   = r_iReady;
    assign d_ready   = r_dReady;

    // The memory port carries one direction at a time
    assert property (@(posedge clk) disable iff (rst) !(r_memRead && r_memWrite));

    // Only one requester is ever told it has completed in a given cycle
    assert property (@(posedge clk) disable iff (rst) !(r_iReady && r_dReady));

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single external main-memory port between the instruction-cache miss path and the data-cache miss/write-back path.
- Sits between both cache controllers and the memory model/bus.
- Serialises block-sized transactions with round-robin priority.
- Registers every memory-side strobe and every requester-side completion.

Parameters:
ADDR_W, 28, block address width (word address minus block-offset bits)
DATA_W, 128, block data width (4 words)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
i_read  input  1  I-cache block read request, level, held until i_ready
i_addr  input  ADDR_W  I-cache block address
i_rdata  output  DATA_W  block returned to I-cache
i_ready  output  1  one-cycle completion pulse to I-cache
d_read  input  1  D-cache block read request, level, held until d_ready
d_write  input  1  D-cache block write request, level, held until d_ready
d_addr  input  ADDR_W  D-cache block address
d_wdata  input  DATA_W  D-cache write-back block
d_rdata  output  DATA_W  block returned to D-cache
d_ready  output  1  one-cycle completion pulse to D-cache
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory block address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid when mem_ready=1
mem_ready  input  1  memory completion, single-cycle pulse

Behaviour:
- Reset (async, rst=1):
  - All outputs are 0; state=IDLE; prio=I.
  - Strobes drop immediately, with no wait for clk.
  - An in-flight transaction is abandoned; no ready pulse is issued.
- States and transitions:
  - IDLE:
    - Requests sampled each edge.
    - Only I pending -> BUSY_I.
    - Only D pending (d_read|d_write) -> BUSY_D.
    - Both pending -> the requester named by prio wins.
    - On grant, latch address, wdata and direction into registers.
    - mem_read/mem_write go high the cycle after the request is first sampled (1-cycle grant latency).
  - BUSY_I / BUSY_D:
    - mem_read/mem_write, mem_addr and mem_wdata are held stable and unchanged until mem_ready is sampled 1.
    - On the edge where mem_ready=1:
      - Strobes go 0.
      - Owner rdata register <= mem_rdata (read only).
      - Owner ready=1 for exactly one cycle.
      - prio <= the other requester.
      - Next state DONE.
  - DONE:
    - Lasts one cycle; all requests ignored, so the owner can drop its request after seeing ready.
    - Next state IDLE.
- Back-to-back: a completed requester re-requesting, or the other requester waiting, is granted in IDLE. Minimum spacing between the end of one transaction and the start of the next is 2 cycles.
- D direction: d_write=1 -> write (mem_write=1, mem_read=0); else read. d_read and d_write both 1 is illegal; write is served. No read-after-write merging.
- Write completion: d_ready pulses; d_rdata is unchanged.
- i_rdata/d_rdata hold their last loaded value until the owner's next read completes. The non-owner's rdata never changes.
- mem_ready while IDLE or DONE is ignored.
- A request deasserted mid-transaction does not abort it. The memory transaction completes and the ready pulse is still issued.
- Address or wdata changing while BUSY has no effect; the latched values are used.
- mem_read and mem_write are never both 1. i_ready and d_ready are never both 1.
- Fairness: under continuous requests from both sides, grants alternate I, D, I, D…

Test Plan:
- Single I read:
  - Stimulus: i_read=1, i_addr=0x0000010 at cycle 0; memory raises mem_ready at cycle 5 with mem_rdata=0x0123…CDEF.
  - Required: mem_read=1 and mem_addr=0x0000010 during cycles 1–5; i_ready=1 only at cycle 6; i_rdata=0x0123…CDEF thereafter; d_rdata stays 0.
- D write-back:
  - Stimulus: d_write=1, d_addr=0x00000A4, d_wdata=0xDEADBEEF_… at cycle 0; mem_ready at cycle 3.
  - Required: mem_write=1 with the same addr/data during cycles 1–3; mem_read=0 throughout; d_ready pulses at cycle 4; d_rdata unchanged.
- Tie after reset:
  - Stimulus: i_read and d_read both asserted at cycle 0, held until their ready; mem_ready returns 2 cycles after each strobe rises.
  - Required: I served first, D second; a second tie is won by I again.
- Stall robustness:
  - Stimulus: during BUSY_D, toggle d_addr to 0x1FFFFFF and deassert d_read.
  - Required: mem_addr stays at the latched value; d_ready still pulses once.
- Reset mid-operation:
  - Stimulus: assert rst between clock edges during BUSY_I.
  - Required: mem_read=0 immediately; after release, no i_ready pulse; a new i_read is served normally.
- Spurious ready:
  - Stimulus: pulse mem_ready in IDLE.
  - Required: no ready output; rdata registers unchanged.
